// File: rtl/switch_pkg.sv
// Shared switch types: flit format and credit/occupancy width helper.
package switch_pkg;

   localparam int FLIT_W = 32;
   localparam int DST_W  = 4;

   typedef struct packed {
      logic [DST_W-1:0]        dst;
      logic [FLIT_W-DST_W-1:0] payload;
   } flit_t;

   // Width able to hold 0..depth inclusive (occupancy and upstream credit count).
   function automatic int credit_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/switch_ibuf_mem.sv
// Flit storage for one ingress port: one synchronous write port, one async read port.
module switch_ibuf_mem
   import switch_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                     CLK,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  flit_t                    wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output flit_t                    rdata
);

   // No reset: slot validity is tracked entirely by the pointers and count.
   flit_t mem [DEPTH];

   always_ff @(posedge CLK)
      if (we) mem[waddr] <= wdata;

   assign rdata = mem[raddr];

endmodule

// File: rtl/switch_input_buffer.sv
// Ingress flit FIFO with arbiter bid, credit return and optional sticky error flags.
// Define SWITCH_IBUF_ERR_EN to build the overflow/underflow flags; otherwise they read 0.
module switch_input_buffer
   import switch_pkg::*;
#(
   parameter int DEPTH = 8
)
(
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       in_valid,
   input  flit_t                      in_flit,
   input  logic                       grant,
   output logic                       bid,
   output flit_t                      rdata,
   output logic                       credit_out,
   output logic [credit_w(DEPTH)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = credit_w(DEPTH);

   logic [PW-1:0] rptr, wptr;
   logic          empty, full, pop, push;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign pop   = grant & ~empty;
   // A pop on the same edge frees the slot, so a full buffer still accepts.
   assign push  = in_valid & (~full | pop);
   assign bid   = ~empty;

   switch_ibuf_mem #(.DEPTH(DEPTH)) u_mem (
      .CLK   (CLK),
      .we    (push),
      .waddr (wptr),
      .wdata (in_flit),
      .raddr (rptr),
      .rdata (rdata)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         rptr       <= '0;
         wptr       <= '0;
         count      <= '0;
         credit_out <= 1'b0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
         credit_out <= pop;
      end
   end

`ifdef SWITCH_IBUF_ERR_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (in_valid && full && !pop) overflow  <= 1'b1;
         if (grant && empty)           underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_switch_input_buffer.sv
// Self-checking bench for switch_input_buffer: directed table, corner sequences, random vs queue model.
module tb_switch_input_buffer;
   import switch_pkg::*;

   localparam int DEPTH = 8;
   localparam int CW    = credit_w(DEPTH);
`ifdef SWITCH_IBUF_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          nRST = 1'b1;
   logic          in_valid = 1'b0;
   logic          grant = 1'b0;
   flit_t         in_flit = '0;
   logic          bid, credit_out, overflow, underflow;
   flit_t         rdata;
   logic [CW-1:0] count;

   int total = 0;
   int bad   = 0;

   // Reference model: a plain queue of accepted flits plus expected flags.
   flit_t q[$];
   bit    m_credit, m_ovf, m_unf;

   switch_input_buffer #(.DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .in_valid   (in_valid),
      .in_flit    (in_flit),
      .grant      (grant),
      .bid        (bid),
      .rdata      (rdata),
      .credit_out (credit_out),
      .count      (count),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_credit = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
   endtask

   task automatic chk_model();
      chk("count", 32'(count), 32'(q.size()));
      chk("bid", 32'(bid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rdata", rdata, q[0]);
      chk("credit", 32'(credit_out), 32'(m_credit));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("underflow", 32'(underflow), 32'(m_unf));
   endtask

   // Drive one cycle, advance the model by the buffer's rules, check #1 after the edge.
   task automatic step(input bit v, input flit_t f, input bit g);
      int n;
      bit full_m, pop_m, push_m;
      in_valid = v;
      in_flit  = f;
      grant    = g;
      @(posedge CLK);
      n      = q.size();
      full_m = (n == DEPTH);
      pop_m  = g && (n > 0);
      push_m = v && (!full_m || pop_m);
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(f);
      m_credit = pop_m;
      if (ERR && v && full_m && !pop_m) m_ovf = 1'b1;
      if (ERR && g && n == 0)           m_unf = 1'b1;
      #1;
      in_valid = 1'b0;
      grant    = 1'b0;
      chk_model();
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      model_clear();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_bid", 32'(bid), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   typedef struct {
      bit          v;
      logic [31:0] f;
      bit          g;
      int          cnt;
      bit          b;
      logic [31:0] rd;
      bit          cr;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int credits;
      int pv, pg;

      tbl[0] = '{1'b1, 32'hA000_000A, 1'b0, 1, 1'b1, 32'hA000_000A, 1'b0};
      tbl[1] = '{1'b1, 32'hB000_000B, 1'b0, 2, 1'b1, 32'hA000_000A, 1'b0};
      tbl[2] = '{1'b1, 32'hC000_000C, 1'b0, 3, 1'b1, 32'hA000_000A, 1'b0};
      tbl[3] = '{1'b0, 32'h0,         1'b1, 2, 1'b1, 32'hB000_000B, 1'b1};
      tbl[4] = '{1'b0, 32'h0,         1'b1, 1, 1'b1, 32'hC000_000C, 1'b1};
      tbl[5] = '{1'b0, 32'h0,         1'b1, 0, 1'b0, 32'h0,         1'b1};
      tbl[6] = '{1'b0, 32'h0,         1'b0, 0, 1'b0, 32'h0,         1'b0};

      // Reset values, asserted asynchronously before any clock edge.
      #1 nRST = 1'b0;
      #2;
      model_clear();
      chk("rst0_count", 32'(count), 32'd0);
      chk("rst0_bid", 32'(bid), 32'd0);
      chk("rst0_credit", 32'(credit_out), 32'd0);
      chk("rst0_ovf", 32'(overflow), 32'd0);
      chk("rst0_unf", 32'(underflow), 32'd0);
      @(negedge CLK);
      @(negedge CLK);
      nRST = 1'b1;

      // Push A,B,C then drain; first push lands on the first edge after reset release.
      for (int i = 0; i < 7; i++) begin
         step(tbl[i].v, tbl[i].f, tbl[i].g);
         chk("t_count", 32'(count), 32'(tbl[i].cnt));
         chk("t_bid", 32'(bid), 32'(tbl[i].b));
         if (tbl[i].b) chk("t_rdata", rdata, tbl[i].rd);
         chk("t_credit", 32'(credit_out), 32'(tbl[i].cr));
      end

      // Fill to DEPTH, drop a 9th, then push-with-pop while full.
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, flit_t'(32'h100 + i), 1'b0);
      step(1'b1, flit_t'(32'h1FF), 1'b0);
      chk("drop_count", 32'(count), 32'(DEPTH));
      chk("drop_head", rdata, 32'h100);
      chk("drop_ovf", 32'(overflow), 32'(ERR));
      step(1'b1, flit_t'(32'h200), 1'b1);
      chk("fullpp_count", 32'(count), 32'(DEPTH));
      chk("fullpp_head", rdata, 32'h101);
      for (int i = 0; i < DEPTH; i++) step(1'b0, flit_t'(32'h0), 1'b1);
      chk("drain_count", 32'(count), 32'd0);

      // Grant and push together on an empty buffer.
      do_reset();
      step(1'b1, flit_t'(32'h0000_0E0E), 1'b1);
      chk("emp_count", 32'(count), 32'd1);
      chk("emp_credit", 32'(credit_out), 32'd0);
      chk("emp_unf", 32'(underflow), 32'(ERR));
      chk("emp_rdata", rdata, 32'h0000_0E0E);

      // Stream 20 flits at one push and one pop per cycle across pointer wraps.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, flit_t'(32'h300 + i), 1'b0);
      credits = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, flit_t'(32'h400 + i), 1'b1);
         if (credit_out) credits++;
         chk("strm_count", 32'(count), 32'd3);
      end
      chk("strm_credits", 32'(credits), 32'd20);

      // Reset between edges while holding 5 flits with a credit pulse in flight.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, flit_t'(32'h500 + i), 1'b0);
      step(1'b1, flit_t'(32'h505), 1'b1);
      chk("pre_rst_credit", 32'(credit_out), 32'd1);
      #2 nRST = 1'b0;
      grant = 1'b1;
      #1;
      model_clear();
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_bid", 32'(bid), 32'd0);
      chk("mid_rst_credit", 32'(credit_out), 32'd0);
      @(posedge CLK);
      #1 chk("held_rst_credit", 32'(credit_out), 32'd0);
      @(negedge CLK);
      nRST = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, flit_t'(32'h0), 1'b1);

      // Random traffic against the queue model, alternating fill-heavy and drain-heavy phases.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         pv = ((i / 50) % 2 == 0) ? 85 : 30;
         pg = ((i / 50) % 2 == 0) ? 30 : 80;
         step($urandom_range(0, 99) < pv, flit_t'($urandom), $urandom_range(0, 99) < pg);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
